sub32_seq: RTL and testbench

//   Sequential 32-bit subtractor/comparator; the counterpart of the combinational 8-bit

---
 rtl/sub32_seq_pkg.sv | 14 +
 rtl/sub32_seq_sub_slice.sv | 32 +++
 rtl/sub32_seq.sv | 145 ++++++++++++++
 tb/tb_sub32_seq.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/sub32_seq_pkg.sv
// Shared definitions for the sequential slice-wise subtractor.
package sub32_seq_pkg;

  // Bits handled per clock when the top does not override SLICE.
  localparam int unsigned SliceDefault = 8;

  // Controller states; encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/sub32_seq_sub_slice.sv
// One SLICE-bit subtract stage: d = a - b - bin, with borrow out and zero detect.
// The borrow chain is written in generate/propagate form.
module sub32_seq_sub_slice
  import sub32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = SliceDefault
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             zero
);

  logic [WIDTH:0] brw;

  // Borrow lookahead terms: generate = ~a & b, propagate = ~(a ^ b).
  always_comb begin
    brw    = '0;
    d      = '0;
    brw[0] = bin;
    for (int i = 0; i < int'(WIDTH); i++) begin
      d[i]     = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
  end

  assign bout = brw[WIDTH];
  assign zero = ~|d;

endmodule

// File: rtl/sub32_seq.sv
// Sequential subtractor/comparator: computes op_a - op_b one slice per clock, LSB slice
// first, and reports diff plus unsigned/signed less-than and equality flags.
module sub32_seq
  import sub32_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = SliceDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             ltu,
  output logic             lts,
  output logic             eq
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IdxW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("sub32_seq: WIDTH must be a multiple of SLICE");
  end

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q;
  logic              borrow_q;
  logic              zero_q;
  logic [WIDTH-1:0]  a_q, b_q;
  logic [WIDTH-1:0]  diff_q;
  logic              ltu_q, lts_q, eq_q;

  logic [SLICE-1:0]  a_sl, b_sl, d_sl;
  logic              bout_sl, zero_sl;
  logic              last_slice;

  assign last_slice = (idx_q == IdxW'(NSLICE - 1));

  // Select the operand slice addressed by the index counter.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int k = 0; k < int'(NSLICE); k++) begin
      if (idx_q == IdxW'(k)) begin
        a_sl = a_q[k*SLICE +: SLICE];
        b_sl = b_q[k*SLICE +: SLICE];
      end
    end
  end

  sub32_seq_sub_slice #(
    .WIDTH (SLICE)
  ) u_slice (
    .a    (a_sl),
    .b    (b_sl),
    .bin  (borrow_q),
    .d    (d_sl),
    .bout (bout_sl),
    .zero (zero_sl)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StRun;
      end
      StRun: begin
        if (last_slice) state_d = StDone;
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Operand capture, per-slice datapath update and final flag registration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q    <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b1;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      ltu_q    <= 1'b0;
      lts_q    <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q      <= op_a;
            b_q      <= op_b;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b1;
          end
        end
        StRun: begin
          for (int k = 0; k < int'(NSLICE); k++) begin
            if (idx_q == IdxW'(k)) diff_q[k*SLICE +: SLICE] <= d_sl;
          end
          borrow_q <= bout_sl;
          zero_q   <= zero_q & zero_sl;
          idx_q    <= idx_q + 1'b1;
          if (last_slice) begin
            ltu_q <= bout_sl;
            eq_q  <= zero_q & zero_sl;
            // Signs differ: the negative operand is smaller; otherwise no overflow,
            // so the sign of the difference decides.
            lts_q <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? a_q[WIDTH-1] : d_sl[SLICE-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = diff_q;
  assign ltu  = ltu_q;
  assign lts  = lts_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_sub32_seq.sv
// Self-checking bench for sub32_seq: directed corner cases plus random operands,
// compared against plain-arithmetic expectations.
module tb_sub32_seq;

  localparam int NSLICE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] diff;
  logic        ltu, lts, eq;

  int checks = 0;
  int errors = 0;

  sub32_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .ltu       (ltu),
    .lts       (lts),
    .eq        (eq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one accepting edge, then scramble the inputs.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    op_a     = $urandom;
    op_b     = $urandom;
  endtask

  // Wait (bounded) for the result and compare it with the arithmetic model.
  task automatic wait_result(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input bit check_all);
    int          n;
    logic [31:0] exp_diff;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    exp_diff = a - b;
    check({tag, "_latency"}, n, NSLICE);
    check({tag, "_diff"}, diff, exp_diff);
    if (check_all) begin
      check({tag, "_ltu"}, {31'd0, ltu}, {31'd0, (a < b)});
      check({tag, "_lts"}, {31'd0, lts}, {31'd0, ($signed(a) < $signed(b))});
      check({tag, "_eq"}, {31'd0, eq}, {31'd0, (a == b)});
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_release_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b);
    start_op(a, b);
    wait_result(tag, a, b, 1'b1);
    release_result(tag);
  endtask

  initial begin
    logic [31:0] ra, rb;

    // Reset state.
    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_diff", diff, 32'd0);
    check("rst_flags", {29'd0, ltu, lts, eq}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed cases.
    do_op("t1_5m3", 32'd5, 32'd3);
    do_op("t2_ripple", 32'h0000_0100, 32'h0000_0001);
    do_op("t3_0m1", 32'd0, 32'd1);
    do_op("t3_minneg", 32'h8000_0000, 32'd1);
    do_op("t4_equal", 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_op("t4_upper", 32'h0001_0000, 32'd0);
    do_op("t_signed_mix", 32'h7FFF_FFFF, 32'h8000_0000);

    // Backpressure: result held while a new request waits upstream.
    start_op(32'h1234_5678, 32'h0000_FFFF);
    wait_result("t5_bp", 32'h1234_5678, 32'h0000_FFFF, 1'b1);
    in_valid  = 1'b1;
    op_a      = 32'h0000_0001;
    op_b      = 32'h0000_0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
      check("t5_hold_ready", {31'd0, in_ready}, 32'd0);
      check("t5_hold_diff", diff, 32'h1234_5678 - 32'h0000_FFFF);
    end
    in_valid = 1'b0;
    release_result("t5_bp");
    do_op("t5_next", 32'd100, 32'd42);

    // Reset in the middle of a computation.
    start_op(32'd0, 32'hFFFF_FFFF);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_diff", diff, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    do_op("t6_7m9", 32'd7, 32'd9);

    // Random operands, occasionally forcing equality or shared upper bits.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 7 == 0) rb = ra;
      if (i % 5 == 1) rb = {ra[31:8], rb[7:0]};
      do_op("rand", ra, rb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
